// File: rtl/peripheral_bus_slave_pkg.sv
// Shared constants for the peripheral bus slave: register offsets from BASE,
// TCON bit positions and the UART transmitter state encoding.
package peripheral_bus_slave_pkg;

  // Register offsets from the peripheral window base
  localparam logic [31:0] OFF_TH       = 32'h00;
  localparam logic [31:0] OFF_TL       = 32'h04;
  localparam logic [31:0] OFF_TCON     = 32'h08;
  localparam logic [31:0] OFF_LED      = 32'h0C;
  localparam logic [31:0] OFF_SWITCH   = 32'h10;
  localparam logic [31:0] OFF_DIGI     = 32'h14;
  localparam logic [31:0] OFF_UART_TXD = 32'h18;
  localparam logic [31:0] OFF_UART_CON = 32'h1C;

  // TCON bit indices
  localparam int TCON_EN = 0;  // timer enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status (sticky)

  // UART transmitter states
  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_core.sv
// Byte-wide 8N1 UART transmitter.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset (line returns to idle-high at once)
//   start  - one-cycle request; accepted only while idle
//   data   - byte to send, captured on an accepted start
//   busy   - high from the accepting edge until the stop bit completes
//   tx     - serial output, LSB first, 1 start bit, 1 stop bit
module uart_tx_core
  import peripheral_bus_slave_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_done;

  assign bit_done = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= UART_IDLE;
      baud  <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          if (start) begin
            shreg <= data;
            baud  <= '0;
            idx   <= '0;
            state <= UART_START;
          end
        end
        UART_START: begin
          if (bit_done) begin
            baud  <= '0;
            state <= UART_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            baud <= '0;
            idx  <= idx + 3'd1;
            // idx wraps 7 -> 0 on the same edge we leave for STOP
            if (idx == 3'd7) state <= UART_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin // UART_STOP
          if (bit_done) begin
            baud  <= '0;
            state <= UART_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

  // tx is decoded from registered state only, so reset forces it high
  // asynchronously without waiting for a clock.
  always_comb begin
    tx = 1'b1;
    case (state)
      UART_START: tx = 1'b0;
      UART_DATA:  tx = shreg[idx];
      default:    tx = 1'b1;
    endcase
  end

  assign busy = (state != UART_IDLE);

endmodule

// File: rtl/peripheral_bus_slave.sv
// Memory-mapped peripheral responder for the CPU peripheral port.
// Holds a reloadable 32-bit timer with interrupt, LED / switch / 7-segment
// registers and a UART transmitter.
// Ports:
//   clk, reset      - system clock, asynchronous active-low reset
//   rd, wr          - peripheral read / write strobes
//   addr, wdata     - byte address and write data from the CPU
//   rdata           - combinational read data (0 when rd is low or unmapped)
//   switch          - board switches (read-only register)
//   led, digi       - LED register and 7-segment {anode[3:0], seg[7:0]}
//   irqout          - timer interrupt request
//   uart_tx         - serial transmit line
module peripheral_bus_slave
  import peripheral_bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h40000000,
  parameter int          CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout,
  output logic        uart_tx
);

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  txd;
  logic        tx_busy;

  // Full 32-bit address decode
  logic hit_th, hit_tl, hit_tcon, hit_led, hit_sw, hit_digi, hit_txd, hit_ucon;
  assign hit_th   = (addr == BASE + OFF_TH);
  assign hit_tl   = (addr == BASE + OFF_TL);
  assign hit_tcon = (addr == BASE + OFF_TCON);
  assign hit_led  = (addr == BASE + OFF_LED);
  assign hit_sw   = (addr == BASE + OFF_SWITCH);
  assign hit_digi = (addr == BASE + OFF_DIGI);
  assign hit_txd  = (addr == BASE + OFF_UART_TXD);
  assign hit_ucon = (addr == BASE + OFF_UART_CON);

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, uart_start;
  assign wr_th      = wr & hit_th;
  assign wr_tl      = wr & hit_tl;
  assign wr_tcon    = wr & hit_tcon;
  assign wr_led     = wr & hit_led;
  assign wr_digi    = wr & hit_digi;
  // TXD writes while a frame is in flight are dropped entirely
  assign uart_start = wr & hit_txd & ~tx_busy;

  // Overflow raises status if interrupts are enabled either now or by a
  // TCON write landing on the same edge, so a racing enable cannot lose it.
  logic tl_wrap, set_is;
  assign tl_wrap = tcon[TCON_EN] & (tl == 32'hFFFF_FFFF);
  assign set_is  = tl_wrap & (tcon[TCON_IE] | (wr_tcon & wdata[TCON_IE]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= '0;
      txd  <= '0;
    end else begin
      if (wr_th) th <= wdata;

      // CPU write beats the timer increment / reload
      if (wr_tl)               tl <= wdata;
      else if (tcon[TCON_EN])  tl <= tl_wrap ? th : tl + 32'd1;

      if (wr_tcon)     tcon <= {wdata[TCON_IS] | set_is, wdata[TCON_IE:TCON_EN]};
      else if (set_is) tcon[TCON_IS] <= 1'b1;

      if (wr_led)     led  <= wdata[7:0];
      if (wr_digi)    digi <= wdata[11:0];
      if (uart_start) txd  <= wdata[7:0];
    end
  end

  assign irqout = tcon[TCON_IS] & tcon[TCON_IE];

  // Reads see register state before any same-cycle write
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if      (hit_th)   rdata = th;
      else if (hit_tl)   rdata = tl;
      else if (hit_tcon) rdata = {29'h0, tcon};
      else if (hit_led)  rdata = {24'h0, led};
      else if (hit_sw)   rdata = {24'h0, switch};
      else if (hit_digi) rdata = {20'h0, digi};
      else if (hit_txd)  rdata = {24'h0, txd};
      else if (hit_ucon) rdata = {31'h0, tx_busy};
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (wdata[7:0]),
    .busy  (tx_busy),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_peripheral_bus_slave.sv
// Directed bench for peripheral_bus_slave with a short UART bit time.
module tb_peripheral_bus_slave;

  localparam logic [31:0] A_TH   = 32'h40000000;
  localparam logic [31:0] A_TL   = 32'h40000004;
  localparam logic [31:0] A_TCON = 32'h40000008;
  localparam logic [31:0] A_LED  = 32'h4000000C;
  localparam logic [31:0] A_SW   = 32'h40000010;
  localparam logic [31:0] A_DIGI = 32'h40000014;
  localparam logic [31:0] A_TXD  = 32'h40000018;
  localparam logic [31:0] A_UCON = 32'h4000001C;
  localparam logic [31:0] A_BAD  = 32'h40000040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch = '0;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout, uart_tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peripheral_bus_slave #(
    .BASE(32'h40000000),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .digi(digi),
    .irqout(irqout), .uart_tx(uart_tx)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    @(negedge clk); reset = 1'b1;
    bus_read(A_TCON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tcon: got %h want 0", d); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx2: got %b want 1", uart_tx); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irqout); end
    checks++; if (led !== 8'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
    checks++; if (digi !== 12'h0) begin errors++; $display("FAIL reset_digi: got %h want 0", digi); end
  endtask

  task automatic test_timer;
    logic [31:0] d;
    bus_write(A_TH, 32'hFFFFFFFC);
    bus_write(A_TL, 32'hFFFFFFFE);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL tl_start: got %h want fffffffe", d); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL tl_max: got %h want ffffffff", d); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFC) begin errors++; $display("FAIL tl_reload: got %h want fffffffc", d); end
    checks++; if (irqout !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irqout); end
    bus_read(A_TCON, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL tcon_irq: got %h want 7", d); end
    // Clear irq by disabling it; timer keeps running and wraps again
    bus_write(A_TCON, 32'h1);
    bus_read(A_TCON, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL tcon_clr: got %h want 1", d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irqout); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFC) begin errors++; $display("FAIL tl_rewrap: got %h want fffffffc", d); end
    bus_read(A_TCON, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL tcon_noirq: got %h want 1", d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL irq_noirq: got %b want 0", irqout); end
    // TL write beats increment, then TCON write lands on the overflow edge
    bus_write(A_TL, 32'hFFFFFFFF);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL tcon_collide: got %h want 7", d); end
    checks++; if (irqout !== 1'b1) begin errors++; $display("FAIL irq_collide: got %b want 1", irqout); end
    // Stop the timer: TL freezes
    bus_write(A_TCON, 32'h0);
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL tl_frozen1: got %h want fffffffe", d); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL tl_frozen2: got %h want fffffffe", d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL irq_off: got %b want 0", irqout); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(A_LED, 32'h1FF);
    bus_write(A_DIGI, 32'hFFFF);
    #1;
    checks++; if (led !== 8'hFF) begin errors++; $display("FAIL led_out: got %h want ff", led); end
    checks++; if (digi !== 12'hFFF) begin errors++; $display("FAIL digi_out: got %h want fff", digi); end
    bus_read(A_LED, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL led_rd: got %h want ff", d); end
    bus_read(A_DIGI, d);
    checks++; if (d !== 32'hFFF) begin errors++; $display("FAIL digi_rd: got %h want fff", d); end
    switch = 8'h5A;
    bus_read(A_SW, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL sw_rd: got %h want 5a", d); end
    bus_write(A_SW, 32'h00);
    bus_read(A_SW, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL sw_ro: got %h want 5a", d); end
    @(negedge clk); rd = 1'b0; addr = A_LED; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_low: got %h want 0", rdata); end
    bus_read(A_BAD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 0", d); end
  endtask

  task automatic test_uart;
    logic [31:0] d;
    logic [9:0]  frame;
    frame = 10'b1101001010; // start, A5 LSB first, stop
    bus_write(A_TXD, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; addr = A_UCON;
      #1;
      checks++; if (uart_tx !== frame[i/4]) begin errors++; $display("FAIL uart_bit[%0d]: got %b want %b", i, uart_tx, frame[i/4]); end
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL uart_busy[%0d]: got %h want 1", i, rdata); end
      if (i == 15) begin addr = A_TXD; wdata = 32'h3C; wr = 1'b1; end
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b1; addr = A_UCON;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL uart_idle: got %h want 0", rdata); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL uart_idle_tx: got %b want 1", uart_tx); end
    rd = 1'b0;
    bus_read(A_TXD, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL uart_txd: got %h want a5", d); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    bus_write(A_TL, 32'h100);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TXD, 32'h00);
    repeat (8) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_data: got %b want 0", uart_tx); end
    #2 reset = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
    rd = 1'b1; addr = A_TL; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_tl: got %h want 0", rdata); end
    addr = A_UCON; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", rdata); end
    rd = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL no_resume: got %b want 1", uart_tx); end
    bus_read(A_UCON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_busy: got %h want 0", d); end
    bus_read(A_BAD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_unmapped: got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_timer;
    test_regs;
    test_uart;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
